// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scan-code constants,
// receiver/decoder state encodings, the key-level bundle and a small helper
// that applies an extended-code make/break to that bundle.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Frame receiver: start bit -> 8 data bits -> parity -> stop.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Prefix tracker for the byte stream (E0 = extended, F0 = break).
    typedef enum logic [1:0] {
        DEC_NORM,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic enter;
    } keys_t;

    // Odd parity over {data, parity}: true when the nine bits hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Extended-set codes (arrows and keypad enter) drive a key to 'level';
    // anything else leaves the keys alone.
    function automatic keys_t apply_ext(input keys_t k, input logic [7:0] code, input logic level);
        keys_t r;
        r = k;
        case (code)
            SC_UP:    r.up    = level;
            SC_DOWN:  r.down  = level;
            SC_LEFT:  r.left  = level;
            SC_RIGHT: r.right = level;
            SC_ENTER: r.enter = level;
            default:  r = k;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle between the PS/2 key decoder and its surroundings: raw PS/2 lines
// in, key levels / scan byte / status pulses out, plus the two FSM states
// for observation.
//
// Handshake: scan_valid is a one-cycle strobe with no ready; scan_code is
// valid in the strobe cycle and holds until the next accepted byte.
// frame_err is a one-cycle strobe and never coincides with scan_valid.
// Key levels are plain levels with no handshake.
interface ps2_key_decoder_if;
    import ps2_pkg::*;

    logic       PS2_clk;
    logic       PS2_data;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       enter;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;
    rx_state_t  rx_state;
    dec_state_t dec_state;

    // Decoder side.
    modport master (
        input  PS2_clk, PS2_data,
        output up, down, left, right, enter,
        output scan_code, scan_valid, frame_err,
        output rx_state, dec_state
    );

    // Keyboard / consumer side.
    modport slave (
        output PS2_clk, PS2_data,
        input  up, down, left, right, enter,
        input  scan_code, scan_valid, frame_err,
        input  rx_state, dec_state
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, detects falling edges of
// the PS/2 clock, shifts in an 11-bit frame and emits one byte with a
// valid or error pulse. A frame stalled longer than TIMEOUT_CYCLES is
// abandoned.
// Optional build macro: PS2_PARITY_CHECK_EN (reject frames with even parity).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output rx_state_t  rx_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_CHECK = 1'b1;
`else
    localparam logic PARITY_CHECK = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    rx_state_t     state_q, state_n;
    logic [7:0]    shift_q, shift_n;
    logic [2:0]    bit_cnt_q, bit_cnt_n;
    logic          par_q, par_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic [7:0]    byte_q, byte_n;
    logic          valid_q, valid_n;
    logic          err_q, err_n;
    logic          par_good;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Synchronizers; reset to the idle-high line level so no edge is seen on release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Receiver state, datapath and registered output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RX_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
            par_q     <= par_n;
            tmo_q     <= tmo_n;
            byte_q    <= byte_n;
            valid_q   <= valid_n;
            err_q     <= err_n;
        end
    end

    // With parity checking off the parity bit is still captured but always passes.
    assign par_good = odd_parity_ok(shift_q, par_q) || !PARITY_CHECK;

    // Next-state logic: advance one bit per PS/2 falling edge, with a timeout override.
    always_comb begin
        state_n   = state_q;
        shift_n   = shift_q;
        bit_cnt_n = bit_cnt_q;
        par_n     = par_q;
        byte_n    = byte_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (state_q == RX_IDLE || fall) begin
            tmo_n = '0;
        end else begin
            tmo_n = tmo_q + 1'b1;
        end

        case (state_q)
            RX_IDLE: begin
                if (fall && !data_s) begin
                    state_n   = RX_DATA;
                    shift_n   = '0;
                    bit_cnt_n = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shift_n   = {data_s, shift_q[7:1]};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_n = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_n   = data_s;
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_n = RX_IDLE;
                    if (data_s && par_good) begin
                        byte_n  = shift_q;
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase

        // A stalled frame is dropped; no falling edge this cycle, so no accept can collide.
        if (state_q != RX_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n   = RX_IDLE;
            shift_n   = '0;
            bit_cnt_n = '0;
            tmo_n     = '0;
            err_n     = 1'b1;
        end
    end

    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_state = state_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder top: frame receiver plus the E0/F0 prefix tracker and the
// held-level registers for up/down/left/right/enter. Accepted bytes are also
// reported raw on scan_code/scan_valid (AA/FA included).
// Optional build macro: PS2_PARITY_CHECK_EN (handled in ps2_frame_rx).
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    ps2_key_decoder_if.master     bus
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    rx_state_t  rx_state;

    dec_state_t dec_q, dec_n;
    keys_t      keys_q, keys_n;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rstn     (rstn),
        .ps2_clk  (bus.PS2_clk),
        .ps2_data (bus.PS2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_state (rx_state)
    );

    // Decoder state and key levels; keys land one cycle after scan_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dec_q  <= DEC_NORM;
            keys_q <= '0;
        end else begin
            dec_q  <= dec_n;
            keys_q <= keys_n;
        end
    end

    // Prefix tracking: every accepted byte either sets a prefix state or
    // completes a make/break and returns to NORM. E0 always opens an extended code.
    always_comb begin
        dec_n  = dec_q;
        keys_n = keys_q;
        if (rx_valid) begin
            dec_n = DEC_NORM;
            if (rx_byte == SC_EXT) begin
                dec_n = DEC_EXT;
            end else begin
                case (dec_q)
                    DEC_NORM: begin
                        if (rx_byte == SC_BRK) begin
                            dec_n = DEC_BRK;
                        end else if (rx_byte == SC_ENTER) begin
                            keys_n.enter = 1'b1;
                        end
                    end
                    DEC_EXT: begin
                        if (rx_byte == SC_BRK) begin
                            dec_n = DEC_EXT_BRK;
                        end else begin
                            keys_n = apply_ext(keys_q, rx_byte, 1'b1);
                        end
                    end
                    DEC_BRK: begin
                        if (rx_byte == SC_ENTER) begin
                            keys_n.enter = 1'b0;
                        end
                    end
                    DEC_EXT_BRK: begin
                        keys_n = apply_ext(keys_q, rx_byte, 1'b0);
                    end
                    default: dec_n = DEC_NORM;
                endcase
            end
        end
    end

    assign bus.up         = keys_q.up;
    assign bus.down       = keys_q.down;
    assign bus.left       = keys_q.left;
    assign bus.right      = keys_q.right;
    assign bus.enter      = keys_q.enter;
    assign bus.scan_code  = rx_byte;
    assign bus.scan_valid = rx_valid;
    assign bus.frame_err  = rx_err;
    assign bus.rx_state   = rx_state;
    assign bus.dec_state  = dec_q;

endmodule
